// File: rtl/sv32_ptw.sv
// Sv32 hardware page-table walker serving ITLB misses.
// Walks two levels through a single-outstanding read port and returns a one-cycle refill or fault.
module sv32_ptw #(
  parameter int PADDR_WD = 34,
  parameter int VADDR_WD = 32,
  parameter int ASID_WD  = 9,
  parameter int PTE_WD   = 32,
  parameter int PPN_WD   = 22
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [PPN_WD-1:0]        satp_ppn_i,
  input  logic                     priv_u_i,
  input  logic                     miss_valid_i,
  output logic                     miss_ready_o,
  input  logic [VADDR_WD-13:0]     miss_vpn_i,
  input  logic [ASID_WD-1:0]       miss_asid_i,
  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  output logic [PADDR_WD-1:0]      mem_req_addr_o,
  input  logic                     mem_rsp_valid_i,
  input  logic [PTE_WD-1:0]        mem_rsp_data_i,
  input  logic                     mem_rsp_err_i,
  output logic                     refill_valid_o,
  output logic [VADDR_WD-13:0]     refill_vpn_o,
  output logic [ASID_WD-1:0]       refill_asid_o,
  output logic [PTE_WD-1:0]        refill_pte_o,
  output logic                     refill_super_o,
  output logic                     page_fault_o,
  output logic                     access_fault_o
);

  localparam int VPN_WD     = VADDR_WD - 12;
  localparam int VPN_LVL_WD = VPN_WD / 2;
  localparam int OFS_PAD    = PADDR_WD - VPN_LVL_WD - 2;

  typedef enum logic [2:0] {
    S_IDLE, S_L1_REQ, S_L1_WAIT, S_L0_REQ, S_L0_WAIT, S_DONE, S_DRAIN
  } state_e;

  typedef enum logic [1:0] {RES_REFILL, RES_PAGE, RES_ACCESS} res_e;

  state_e              state_q, state_d;
  res_e                res_q, res_d;
  logic [VPN_WD-1:0]   vpn_q, vpn_d;
  logic [ASID_WD-1:0]  asid_q, asid_d;
  logic                priv_q, priv_d;
  logic [PPN_WD-1:0]   satp_q, satp_d;
  logic [PPN_WD-1:0]   l0_ppn_q, l0_ppn_d;
  logic [PTE_WD-1:0]   pte_q, pte_d;
  logic                super_q, super_d;
  logic                abort_q, abort_d;

  logic [PADDR_WD-1:0] l1_addr, l0_addr;
  logic pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, in_l1, sp_misaligned;

  assign l1_addr = {satp_q, 12'h000}   + {{OFS_PAD{1'b0}}, vpn_q[VPN_WD-1 -: VPN_LVL_WD], 2'b00};
  assign l0_addr = {l0_ppn_q, 12'h000} + {{OFS_PAD{1'b0}}, vpn_q[VPN_LVL_WD-1:0], 2'b00};

  assign pte_v         = mem_rsp_data_i[0];
  assign pte_r         = mem_rsp_data_i[1];
  assign pte_w         = mem_rsp_data_i[2];
  assign pte_x         = mem_rsp_data_i[3];
  assign pte_u         = mem_rsp_data_i[4];
  assign pte_a         = mem_rsp_data_i[6];
  assign in_l1         = (state_q == S_L1_WAIT);
  assign sp_misaligned = |mem_rsp_data_i[19:10];

  always_comb begin
    state_d         = state_q;
    res_d           = res_q;
    vpn_d           = vpn_q;
    asid_d          = asid_q;
    priv_d          = priv_q;
    satp_d          = satp_q;
    l0_ppn_d        = l0_ppn_q;
    pte_d           = pte_q;
    super_d         = super_q;
    abort_d         = abort_q;
    miss_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_addr_o  = '0;
    refill_valid_o  = 1'b0;
    page_fault_o    = 1'b0;
    access_fault_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) begin
          vpn_d   = miss_vpn_i;
          asid_d  = miss_asid_i;
          priv_d  = priv_u_i;
          satp_d  = satp_ppn_i;
          abort_d = 1'b0;
          state_d = S_L1_REQ;
        end
      end
      S_L1_REQ, S_L0_REQ: begin
        // A flushed request cannot be retracted; remember the abort until it is accepted.
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = (state_q == S_L1_REQ) ? l1_addr : l0_addr;
        if (flush_i) abort_d = 1'b1;
        if (mem_req_ready_i) begin
          abort_d = 1'b0;
          if (abort_q || flush_i)      state_d = S_DRAIN;
          else if (state_q == S_L1_REQ) state_d = S_L1_WAIT;
          else                          state_d = S_L0_WAIT;
        end
      end
      S_L1_WAIT, S_L0_WAIT: begin
        if (mem_rsp_valid_i) begin
          if (flush_i) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            res_d   = RES_PAGE;
            if (mem_rsp_err_i) begin
              res_d = RES_ACCESS;
            end else if (!pte_v || (!pte_r && pte_w)) begin
              res_d = RES_PAGE;
            end else if (!pte_r && !pte_x) begin
              if (in_l1) begin
                l0_ppn_d = mem_rsp_data_i[PTE_WD-1:10];
                state_d  = S_L0_REQ;
              end
            end else if (!pte_x || !pte_a || (priv_q != pte_u) || (in_l1 && sp_misaligned)) begin
              res_d = RES_PAGE;
            end else begin
              res_d   = RES_REFILL;
              pte_d   = mem_rsp_data_i;
              super_d = in_l1;
            end
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (!flush_i) begin
          refill_valid_o = (res_q == RES_REFILL);
          page_fault_o   = (res_q == RES_PAGE);
          access_fault_o = (res_q == RES_ACCESS);
        end
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (mem_rsp_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      res_q    <= RES_PAGE;
      vpn_q    <= '0;
      asid_q   <= '0;
      priv_q   <= 1'b0;
      satp_q   <= '0;
      l0_ppn_q <= '0;
      pte_q    <= '0;
      super_q  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      vpn_q    <= vpn_d;
      asid_q   <= asid_d;
      priv_q   <= priv_d;
      satp_q   <= satp_d;
      l0_ppn_q <= l0_ppn_d;
      pte_q    <= pte_d;
      super_q  <= super_d;
      abort_q  <= abort_d;
    end
  end

  assign refill_vpn_o   = vpn_q;
  assign refill_asid_o  = asid_q;
  assign refill_pte_o   = pte_q;
  assign refill_super_o = super_q;

endmodule

// File: tb/tb_sv32_ptw.sv
// Bench for sv32_ptw: directed walks from the plan plus randomized walks
// checked against a table-driven reference walk over a sparse memory model.
module tb_sv32_ptw;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic [21:0] satp_ppn_i = '0;
  logic        priv_u_i = 1'b0;
  logic        miss_valid_i = 1'b0;
  logic        miss_ready_o;
  logic [19:0] miss_vpn_i = '0;
  logic [8:0]  miss_asid_i = '0;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic [33:0] mem_req_addr_o;
  logic        mem_rsp_valid_i = 1'b0;
  logic [31:0] mem_rsp_data_i = '0;
  logic        mem_rsp_err_i = 1'b0;
  logic        refill_valid_o;
  logic [19:0] refill_vpn_o;
  logic [8:0]  refill_asid_o;
  logic [31:0] refill_pte_o;
  logic        refill_super_o;
  logic        page_fault_o;
  logic        access_fault_o;

  sv32_ptw dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .satp_ppn_i(satp_ppn_i),
    .priv_u_i(priv_u_i), .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
    .miss_vpn_i(miss_vpn_i), .miss_asid_i(miss_asid_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_err_i(mem_rsp_err_i),
    .refill_valid_o(refill_valid_o), .refill_vpn_o(refill_vpn_o),
    .refill_asid_o(refill_asid_o), .refill_pte_o(refill_pte_o),
    .refill_super_o(refill_super_o), .page_fault_o(page_fault_o),
    .access_fault_o(access_fault_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int acc_cnt = 0;

  always @(posedge clk_i) begin
    if (refill_valid_o || page_fault_o || access_fault_o) pulse_cnt++;
    if (mem_req_valid_o && mem_req_ready_i) acc_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // sparse physical memory holding PTEs, plus per-address bus-error flags
  logic [31:0] mem_data [logic [33:0]];
  bit          mem_err  [logic [33:0]];
  logic [33:0] exp_addr_q [$];

  function automatic logic [31:0] rd_data(input logic [33:0] a);
    return mem_data.exists(a) ? mem_data[a] : 32'h0;
  endfunction

  function automatic bit rd_err(input logic [33:0] a);
    return mem_err.exists(a) ? mem_err[a] : 1'b0;
  endfunction

  task automatic clear_mem();
    mem_data.delete();
    mem_err.delete();
  endtask

  // Reference walk: kind 0 = refill, 1 = page fault, 2 = access fault.
  function automatic void model(input logic [21:0] satp, input logic [19:0] vpn, input logic priv,
                                output int kind, output logic [31:0] pte, output logic sup);
    logic [33:0] base, a;
    logic [31:0] p;
    int idx;
    exp_addr_q.delete();
    kind = 1; pte = '0; sup = 1'b0;
    base = 34'(satp) * 4096;
    for (int lvl = 1; lvl >= 0; lvl--) begin
      idx = (lvl == 1) ? int'(vpn / 1024) : int'(vpn % 1024);
      a = base + 34'(idx * 4);
      exp_addr_q.push_back(a);
      p = rd_data(a);
      if (rd_err(a)) begin kind = 2; return; end
      if (p[0] == 1'b0 || (p[1] == 1'b0 && p[2] == 1'b1)) begin kind = 1; return; end
      if (p[1] == 1'b0 && p[3] == 1'b0) begin
        if (lvl == 0) begin kind = 1; return; end
        base = 34'(p / 1024) * 4096;
        continue;
      end
      if (p[3] == 1'b0 || p[6] == 1'b0)   kind = 1;
      else if (priv && !p[4])             kind = 1;
      else if (!priv && p[4])             kind = 1;
      else if (lvl == 1 && ((p / 1024) % 1024) != 0) kind = 1;
      else begin kind = 0; pte = p; sup = (lvl == 1); end
      return;
    end
  endfunction

  function automatic logic [31:0] gen_pte(input logic priv);
    logic [31:0] p;
    p = $urandom;
    case ($urandom_range(0, 5))
      0: ;
      1, 2: p[3:0] = 4'b0001;
      default: begin
        p[0] = 1'b1;
        p[1] = 1'b1;
        p[3] = ($urandom_range(0, 5) != 0);
        p[6] = ($urandom_range(0, 5) != 0);
        p[4] = ($urandom_range(0, 3) != 0) ? priv : ~priv;
        if ($urandom_range(0, 1) == 1) p[19:10] = '0;
      end
    endcase
    return p;
  endfunction

  task automatic start(input logic [21:0] satp, input logic [19:0] vpn, input logic [8:0] asid,
                       input logic priv);
    satp_ppn_i = satp; miss_vpn_i = vpn; miss_asid_i = asid; priv_u_i = priv;
    miss_valid_i = 1'b1;
    @(negedge clk_i);
    miss_valid_i = 1'b0;
  endtask

  task automatic do_walk(input logic [21:0] satp, input logic [19:0] vpn, input logic [8:0] asid,
                         input logic priv, input int stall0, input string tag);
    int exp_kind, obs, nreq, lat, cyc, stall, since_rsp;
    logic [31:0] exp_pte;
    logic exp_sup, pending, held, done;
    logic [33:0] held_addr, cur_addr;
    model(satp, vpn, priv, exp_kind, exp_pte, exp_sup);
    nreq = 0; lat = 0; cyc = 0; stall = stall0; since_rsp = -1;
    pending = 0; held = 0; done = 0; held_addr = '0; cur_addr = '0;
    chk({tag, "_rdy_idle"}, miss_ready_o, 1);
    start(satp, vpn, asid, priv);
    satp_ppn_i = 22'($urandom);
    priv_u_i = ~priv;
    while (!done && cyc < 300) begin
      mem_rsp_valid_i = 1'b0; mem_rsp_err_i = 1'b0; mem_rsp_data_i = $urandom;
      mem_req_ready_i = 1'b0;
      if (refill_valid_o || page_fault_o || access_fault_o) begin
        if (refill_valid_o && !page_fault_o && !access_fault_o)      obs = 0;
        else if (page_fault_o && !refill_valid_o && !access_fault_o) obs = 1;
        else if (access_fault_o && !refill_valid_o && !page_fault_o) obs = 2;
        else obs = 3;
        chk({tag, "_kind"}, obs, exp_kind);
        chk({tag, "_nreq"}, nreq, exp_addr_q.size());
        chk({tag, "_lat"}, (since_rsp >= 1 && since_rsp <= 3), 1);
        if (exp_kind == 0) begin
          chk({tag, "_pte"}, refill_pte_o, exp_pte);
          chk({tag, "_super"}, refill_super_o, exp_sup);
          chk({tag, "_vpn"}, refill_vpn_o, vpn);
          chk({tag, "_asid"}, refill_asid_o, asid);
        end
        done = 1;
      end else begin
        chk({tag, "_busy"}, miss_ready_o, 0);
        if (pending) begin
          chk({tag, "_outst"}, mem_req_valid_o, 0);
          if (lat == 0) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = rd_data(cur_addr);
            mem_rsp_err_i   = rd_err(cur_addr);
            pending = 0;
            since_rsp = 0;
          end else lat--;
        end else if (mem_req_valid_o || held) begin
          if (held) begin
            chk({tag, "_vhold"}, mem_req_valid_o, 1);
            chk({tag, "_ahold"}, mem_req_addr_o, held_addr);
          end
          if (stall > 0 || $urandom_range(0, 3) == 0) begin
            if (stall > 0) stall--;
            held = 1;
            held_addr = mem_req_addr_o;
          end else begin
            mem_req_ready_i = 1'b1;
            if (nreq < exp_addr_q.size()) chk({tag, "_addr"}, mem_req_addr_o, exp_addr_q[nreq]);
            else chk({tag, "_xreq"}, nreq + 1, exp_addr_q.size());
            cur_addr = mem_req_addr_o;
            nreq++;
            pending = 1;
            held = 0;
            lat = $urandom_range(0, 3);
          end
        end
      end
      @(negedge clk_i);
      if (since_rsp >= 0) since_rsp++;
      cyc++;
    end
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_err_i = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_rdy_after"}, miss_ready_o, 1);
    chk({tag, "_one_pulse"}, refill_valid_o | page_fault_o | access_fault_o, 0);
  endtask

  initial begin
    int p0, a0;
    logic [21:0] satp;
    logic [19:0] vpn;
    logic [33:0] l1a, l0a;
    logic [31:0] p1;
    logic pr;

    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_ready", miss_ready_o, 1);
    chk("rst_req", mem_req_valid_o, 0);
    chk("rst_addr", mem_req_addr_o, 0);
    chk("rst_pulses", {refill_valid_o, page_fault_o, access_fault_o}, 0);
    chk("rst_payload", {refill_vpn_o, refill_asid_o, refill_pte_o, refill_super_o}, 0);

    // 4 KiB walk with five cycles of request backpressure
    clear_mem();
    mem_data[34'h80004]  = 32'h00090001;
    mem_data[34'h240004] = 32'h123450CB;
    do_walk(22'h80, 20'h00401, 9'h1A5, 1'b0, 5, "k4");

    clear_mem();
    mem_data[34'h80004] = 32'h2000004B;
    do_walk(22'h80, 20'h00401, 9'h033, 1'b0, 0, "super");
    do_walk(22'h80, 20'h00401, 9'h033, 1'b1, 0, "umode");
    mem_data[34'h80004] = 32'h2000044B;
    do_walk(22'h80, 20'h00401, 9'h034, 1'b0, 0, "misalign");
    mem_data[34'h80004] = 32'h00000000;
    do_walk(22'h80, 20'h00401, 9'h035, 1'b0, 0, "inval");
    mem_data[34'h80004] = 32'h00000005;
    do_walk(22'h80, 20'h00401, 9'h036, 1'b0, 0, "w_no_r");
    mem_data[34'h80004]  = 32'h00090001;
    mem_data[34'h240004] = 32'h00090001;
    do_walk(22'h80, 20'h00401, 9'h037, 1'b0, 0, "l0_ptr");
    mem_err[34'h80004] = 1'b1;
    do_walk(22'h80, 20'h00401, 9'h038, 1'b0, 0, "buserr");

    for (int t = 0; t < 40; t++) begin
      clear_mem();
      satp = 22'($urandom);
      vpn  = 20'($urandom);
      pr   = 1'($urandom);
      l1a  = 34'(satp) * 4096 + 34'(vpn[19:10]) * 4;
      p1   = gen_pte(pr);
      mem_data[l1a] = p1;
      if ($urandom_range(0, 9) == 0) mem_err[l1a] = 1'b1;
      l0a = 34'(p1[31:10]) * 4096 + 34'(vpn[9:0]) * 4;
      if (l0a != l1a) begin
        mem_data[l0a] = gen_pte(pr);
        if ($urandom_range(0, 9) == 0) mem_err[l0a] = 1'b1;
      end
      do_walk(satp, vpn, 9'($urandom), pr, 0, "rnd");
    end

    // flush while waiting for the L1 response
    p0 = pulse_cnt; a0 = acc_cnt;
    start(22'h80, 20'h00401, 9'h011, 1'b0);
    chk("fw_req", mem_req_valid_o, 1);
    mem_req_ready_i = 1'b1; @(negedge clk_i); mem_req_ready_i = 1'b0;
    flush_i = 1'b1; @(negedge clk_i); flush_i = 1'b0;
    repeat (2) begin chk("fw_drain_busy", miss_ready_o, 0); @(negedge clk_i); end
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h00090001; @(negedge clk_i); mem_rsp_valid_i = 1'b0;
    chk("fw_ready", miss_ready_o, 1);
    repeat (4) @(negedge clk_i);
    chk("fw_quiet", pulse_cnt - p0, 0);
    chk("fw_one_req", acc_cnt - a0, 1);

    // flush during L1_REQ while the port stalls
    p0 = pulse_cnt; a0 = acc_cnt;
    start(22'h80, 20'h00401, 9'h012, 1'b0);
    flush_i = 1'b1; @(negedge clk_i); flush_i = 1'b0;
    repeat (3) begin
      chk("fr_vhold", mem_req_valid_o, 1);
      chk("fr_ahold", mem_req_addr_o, 34'h80004);
      @(negedge clk_i);
    end
    mem_req_ready_i = 1'b1; @(negedge clk_i); mem_req_ready_i = 1'b0;
    chk("fr_noreq", mem_req_valid_o, 0);
    chk("fr_busy", miss_ready_o, 0);
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h2000004B; @(negedge clk_i); mem_rsp_valid_i = 1'b0;
    chk("fr_ready", miss_ready_o, 1);
    repeat (4) @(negedge clk_i);
    chk("fr_quiet", pulse_cnt - p0, 0);
    chk("fr_one_req", acc_cnt - a0, 1);

    // flush coinciding with the response goes straight to idle
    p0 = pulse_cnt;
    start(22'h80, 20'h00401, 9'h013, 1'b0);
    mem_req_ready_i = 1'b1; @(negedge clk_i); mem_req_ready_i = 1'b0;
    flush_i = 1'b1; mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h2000004B;
    @(negedge clk_i);
    flush_i = 1'b0; mem_rsp_valid_i = 1'b0;
    chk("fs_ready", miss_ready_o, 1);
    repeat (3) @(negedge clk_i);
    chk("fs_quiet", pulse_cnt - p0, 0);

    // flush in DONE suppresses the pulse
    p0 = pulse_cnt;
    start(22'h80, 20'h00401, 9'h014, 1'b0);
    mem_req_ready_i = 1'b1; @(negedge clk_i); mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h2000004B; @(negedge clk_i); mem_rsp_valid_i = 1'b0;
    chk("fd_pre", refill_valid_o, 1);
    flush_i = 1'b1; #1;
    chk("fd_sup", {refill_valid_o, page_fault_o, access_fault_o}, 0);
    @(negedge clk_i); flush_i = 1'b0;
    chk("fd_ready", miss_ready_o, 1);
    chk("fd_quiet", pulse_cnt - p0, 0);

    // reset while in L0_WAIT, then a stale response
    start(22'h80, 20'h00401, 9'h015, 1'b0);
    mem_req_ready_i = 1'b1; @(negedge clk_i); mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h00090001; @(negedge clk_i); mem_rsp_valid_i = 1'b0;
    chk("rm_l0addr", mem_req_addr_o, 34'h240004);
    mem_req_ready_i = 1'b1; @(negedge clk_i); mem_req_ready_i = 1'b0;
    rst_i = 1'b1; #1;
    chk("rm_ready", miss_ready_o, 1);
    chk("rm_req", {mem_req_valid_o, mem_req_addr_o}, 0);
    chk("rm_pulses", {refill_valid_o, page_fault_o, access_fault_o}, 0);
    chk("rm_payload", {refill_vpn_o, refill_asid_o, refill_pte_o, refill_super_o}, 0);
    @(negedge clk_i); rst_i = 1'b0;
    p0 = pulse_cnt; a0 = acc_cnt;
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h123450CB; @(negedge clk_i); mem_rsp_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("rm_stale", pulse_cnt - p0, 0);
    chk("rm_noreq", acc_cnt - a0, 0);
    chk("rm_idle", miss_ready_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
